// File: rtl/systolic_operand_feeder.sv
// Streams K operand words from the A/B global buffers into a 4x4 PE array,
// skewing lane r by r cycles so each PE sees its operands in wavefront order.
module systolic_operand_feeder #(
  parameter int DW    = 8,
  parameter int WW    = 32,
  parameter int IW    = 8,
  parameter int LANES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    k_len,
  input  logic [IW-1:0] base_a,
  input  logic [IW-1:0] base_b,
  output logic [IW-1:0] idx_a,
  output logic [IW-1:0] idx_b,
  input  logic [WW-1:0] rdata_a,
  input  logic [WW-1:0] rdata_b,
  output logic [WW-1:0] a_skew,
  output logic [WW-1:0] b_skew,
  output logic [3:0]    lane_vld,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    t_reg, t_next;
  logic [3:0]    k_reg, k_next;
  logic [IW-1:0] idx_a_reg, idx_a_next;
  logic [IW-1:0] idx_b_reg, idx_b_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          rd_vld_reg;
  logic [LANES-1:0] vld_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      t_reg      <= '0;
      k_reg      <= '0;
      idx_a_reg  <= '0;
      idx_b_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      rd_vld_reg <= 1'b0;
      vld_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      t_reg      <= t_next;
      k_reg      <= k_next;
      idx_a_reg  <= idx_a_next;
      idx_b_reg  <= idx_b_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      // Buffer data is valid one cycle after an index issued in READ.
      rd_vld_reg <= (state_reg == READ);
      vld_reg    <= {vld_reg[LANES-2:0], rd_vld_reg};
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    k_next     = k_reg;
    idx_a_next = idx_a_reg;
    idx_b_next = idx_b_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // done is still high in the first IDLE cycle; a start there is dropped.
        if (start && !done_reg) begin
          busy_next = 1'b1;
          k_next    = k_len;
          t_next    = '0;
          if (k_len != 4'd0) begin
            state_next = READ;
            idx_a_next = base_a;
            idx_b_next = base_b;
          end else begin
            state_next = FIN;
          end
        end
      end
      READ: begin
        if (t_reg == k_reg - 4'd1) begin
          state_next = DRAIN;
          t_next     = '0;
        end else begin
          t_next     = t_reg + 4'd1;
          idx_a_next = idx_a_reg + 1'b1;
          idx_b_next = idx_b_reg + 1'b1;
        end
      end
      DRAIN: begin
        // Four cycles: capture stage plus three skew stages of lane 3.
        if (t_reg == 4'd3) begin
          state_next = FIN;
          t_next     = '0;
        end else begin
          t_next = t_reg + 4'd1;
        end
      end
      FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int HI = WW - 1 - gi * DW;
      logic [DW-1:0] a_dl [0:gi];
      logic [DW-1:0] b_dl [0:gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s <= gi; s++) begin
            a_dl[s] <= '0;
            b_dl[s] <= '0;
          end
        end else begin
          // Invalid cycles inject zeros so idle lanes feed +0 to the PEs.
          a_dl[0] <= rd_vld_reg ? rdata_a[HI -: DW] : '0;
          b_dl[0] <= rd_vld_reg ? rdata_b[HI -: DW] : '0;
          for (int s = 1; s <= gi; s++) begin
            a_dl[s] <= a_dl[s-1];
            b_dl[s] <= b_dl[s-1];
          end
        end
      end

      assign a_skew[HI -: DW] = a_dl[gi];
      assign b_skew[HI -: DW] = b_dl[gi];
    end
  endgenerate

  assign idx_a    = idx_a_reg;
  assign idx_b    = idx_b_reg;
  assign lane_vld = vld_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder with registered-read buffer models.
module tb_systolic_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  k_len;
  logic [7:0]  base_a, base_b;
  logic [7:0]  idx_a, idx_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] a_skew, b_skew;
  logic [3:0]  lane_vld;
  logic        busy, done;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int tests = 0;
  int fails = 0;

  systolic_operand_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .base_a(base_a), .base_b(base_b), .idx_a(idx_a), .idx_b(idx_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .a_skew(a_skew), .b_skew(b_skew),
    .lane_vld(lane_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_a <= mem_a[idx_a];
    rdata_b <= mem_b[idx_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench just after edge 0 (the edge that samples start).
  task automatic launch(input logic [3:0] k, input logic [7:0] ba, input logic [7:0] bb);
    k_len  = k;
    base_a = ba;
    base_b = bb;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  logic [3:0] exp_vld [10];
  logic [7:0] exp_l2  [10];
  int done_cnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rdata_a = '0;
    rdata_b = '0;
    rst = 1'b1; start = 1'b0; k_len = '0; base_a = '0; base_b = '0;
    tick(); tick();
    chk("rst_a_skew", a_skew, 32'h0);
    chk("rst_lane_vld", {28'h0, lane_vld}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_idx_a", {24'h0, idx_a}, 32'h0);
    rst = 1'b0;
    tick();

    // T1: single word
    mem_a[0] = 32'h01020304;
    mem_b[0] = 32'h05060708;
    launch(4'd1, 8'd0, 8'd0);
    chk("t1_busy_e0", {31'h0, busy}, 32'h1);
    tick(); tick();
    chk("t1_a_e2", a_skew, 32'h01000000);
    chk("t1_b_e2", b_skew, 32'h05000000);
    chk("t1_vld_e2", {28'h0, lane_vld}, 32'h1);
    tick();
    chk("t1_a_e3", a_skew, 32'h00020000);
    chk("t1_vld_e3", {28'h0, lane_vld}, 32'h2);
    tick();
    chk("t1_a_e4", a_skew, 32'h00000300);
    tick();
    chk("t1_a_e5", a_skew, 32'h00000004);
    chk("t1_b_e5", b_skew, 32'h00000008);
    chk("t1_vld_e5", {28'h0, lane_vld}, 32'h8);
    chk("t1_done_e5", {31'h0, done}, 32'h0);
    tick();
    chk("t1_done_e6", {31'h0, done}, 32'h1);
    chk("t1_busy_e6", {31'h0, busy}, 32'h0);
    chk("t1_a_e6", a_skew, 32'h0);
    tick();
    chk("t1_done_e7", {31'h0, done}, 32'h0);

    // T2: four words, lane_vld wavefront and lane 2 bytes
    mem_a[16] = 32'h10111213;
    mem_a[17] = 32'h20212223;
    mem_a[18] = 32'h30313233;
    mem_a[19] = 32'h40414243;
    exp_vld = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    exp_l2  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h22, 8'h32, 8'h42, 8'h00, 8'h00};
    launch(4'd4, 8'd16, 8'd32);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("t2_vld_e%0d", e), {28'h0, lane_vld}, {28'h0, exp_vld[e]});
      chk($sformatf("t2_lane2_e%0d", e), {24'h0, a_skew[15:8]}, {24'h0, exp_l2[e]});
      chk($sformatf("t2_done_e%0d", e), {31'h0, done}, (e == 9) ? 32'h1 : 32'h0);
    end
    tick();

    // T3: index wrap 254 -> 1
    mem_a[254] = 32'hA1A2A3A4;
    mem_a[255] = 32'hB1B2B3B4;
    mem_a[0]   = 32'hC1C2C3C4;
    mem_a[1]   = 32'hD1D2D3D4;
    mem_b[103] = 32'hE1E2E3E4;
    launch(4'd4, 8'd254, 8'd100);
    chk("t3_idx_a_e0", {24'h0, idx_a}, 32'd254);
    tick();
    chk("t3_idx_a_e1", {24'h0, idx_a}, 32'd255);
    tick();
    chk("t3_idx_a_e2", {24'h0, idx_a}, 32'd0);
    chk("t3_l0_e2", {24'h0, a_skew[31:24]}, 32'hA1);
    tick();
    chk("t3_idx_a_e3", {24'h0, idx_a}, 32'd1);
    chk("t3_l0_e3", {24'h0, a_skew[31:24]}, 32'hB1);
    tick();
    chk("t3_idx_a_e4", {24'h0, idx_a}, 32'd1);
    chk("t3_l0_e4", {24'h0, a_skew[31:24]}, 32'hC1);
    tick();
    chk("t3_l0_e5", {24'h0, a_skew[31:24]}, 32'hD1);
    chk("t3_b_l0_e5", {24'h0, b_skew[31:24]}, 32'hE1);
    tick(); tick(); tick(); tick();
    chk("t3_done_e9", {31'h0, done}, 32'h1);
    tick();

    // T4: k_len = 0
    launch(4'd0, 8'd50, 8'd60);
    chk("t4_busy_e0", {31'h0, busy}, 32'h1);
    chk("t4_idx_a_e0", {24'h0, idx_a}, 32'd1);
    chk("t4_idx_b_e0", {24'h0, idx_b}, 32'd103);
    tick();
    chk("t4_done_e1", {31'h0, done}, 32'h1);
    chk("t4_busy_e1", {31'h0, busy}, 32'h0);
    chk("t4_vld_e1", {28'h0, lane_vld}, 32'h0);
    tick();
    chk("t4_done_e2", {31'h0, done}, 32'h0);

    // T5: start while busy and during done are both ignored
    launch(4'd9, 8'd0, 8'd0);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int e = 4; e <= 20; e++) begin
      tick();
      if (done) done_cnt++;
      if (e == 13) chk("t5_done_e13", {31'h0, done}, 32'h0);
      if (e == 14) begin
        chk("t5_done_e14", {31'h0, done}, 32'h1);
        start = 1'b1;
      end
      if (e == 15) begin
        start = 1'b0;
        chk("t5_busy_e15", {31'h0, busy}, 32'h0);
      end
    end
    chk("t5_done_count", done_cnt, 32'd1);

    // T6: asynchronous reset mid-pass, then a clean pass
    launch(4'd4, 8'd16, 8'd32);
    tick(); tick(); tick(); tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_a_skew", a_skew, 32'h0);
    chk("t6_rst_vld", {28'h0, lane_vld}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    chk("t6_rst_idx_a", {24'h0, idx_a}, 32'h0);
    @(negedge clk);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_cnt++;
    end
    rst = 1'b0;
    tick();
    if (done) done_cnt++;
    chk("t6_no_done", done_cnt, 32'd0);
    launch(4'd1, 8'd16, 8'd0);
    tick(); tick();
    chk("t6_a_e2", a_skew, 32'h10000000);
    tick(); tick(); tick(); tick();
    chk("t6_done_e6", {31'h0, done}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
